sweep_response_analyzer: RTL and testbench
==========================================

SWEEP_RESPONSE_ANALYZER -- requirements
Module: sweep_response_analyzer

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 16, sample width per channel (signed two's complement).
REQ-002 The block SHALL have parameter NUM_CH, default 13, number of filter channels observed.
REQ-003 The block SHALL have parameter PERIOD_WIDTH, default 32, width of sine-generator period values.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 32, width of settle/measure counters.
REQ-005 The block SHALL have parameter FLUSH_CYCLES, default 100, cycles dut_run is held low between points.
REQ-006 Ports SHALL be, one per line: clk  in  1  single clock, all logic on rising edge;
        rst  in  1  synchronous, active-high reset;
        start  in  1  one-cycle pulse, begins sweep when idle;
        period_start / period_step / period_stop  in  PERIOD_WIDTH each  sweep definition;
        settle_cycles / measure_cycles  in  CNT_WIDTH each  per-point timing;
        ch_data  in  NUM_CH*WORD_WIDTH  channel k at bits [k*WORD_WIDTH +: WORD_WIDTH];
        ch_valid  in  NUM_CH  per-channel sample qualifier;
        period_out  out  PERIOD_WIDTH  drives sine generator period;
        dut_run  out  1  high = generator/filters running, low = held in reset;
        res_valid  out  1  result word available;  res_ready  in  1  consumer accepts;
        res_period  out  PERIOD_WIDTH;  res_channel  out  8;  res_min / res_max  out  WORD_WIDTH;  res_empty  out  1;
        busy  out  1;  done  out  1  one-cycle pulse at sweep end.

Function
REQ-007 start SHALL be accepted only in IDLE; all six config inputs SHALL be latched on the accepting edge; start while busy SHALL be ignored.
REQ-008 States SHALL be IDLE, FLUSH, SETTLE, MEASURE, REPORT, NEXT; busy SHALL be high in every state except IDLE.
REQ-009 IDLE -> FLUSH on accepted start; period_out SHALL take period_start on the same edge.
REQ-010 FLUSH SHALL last exactly FLUSH_CYCLES cycles with dut_run=0; dut_run SHALL be high in SETTLE and MEASURE only.
REQ-011 SETTLE SHALL last exactly settle_cycles cycles; settle_cycles=0 SHALL go FLUSH -> MEASURE directly.
REQ-012 MEASURE SHALL last exactly max(measure_cycles,1) cycles; per channel, min/max trackers SHALL be cleared on MEASURE entry and updated with signed compare only on cycles where ch_valid[k]=1.
REQ-013 A channel with no valid sample during MEASURE SHALL report res_empty=1, res_min=most-positive, res_max=most-negative value.
REQ-014 REPORT SHALL present NUM_CH results in channel order 0..NUM_CH-1, res_period = current period_out; res_valid SHALL stay high and all res_* stable until res_ready; one result transfers per cycle with valid&ready.
REQ-015 After channel NUM_CH-1 transfers, REPORT -> NEXT; NEXT SHALL compute next = period_out + period_step at PERIOD_WIDTH+1 bits.
REQ-016 NEXT SHALL go to FLUSH with period_out=next if period_step!=0, no carry out, and next <= period_stop; otherwise pulse done for one cycle and go IDLE.
REQ-017 period_start > period_stop SHALL still measure exactly one point at period_start.
REQ-018 period_out SHALL hold its value in IDLE after a sweep; it SHALL change only in IDLE-accept and NEXT.
REQ-019 Inputs ch_data/ch_valid SHALL be sampled unregistered on the MEASURE cycle; tracker update latency one cycle, no additional pipeline.

Reset
REQ-020 rst high on any edge, including mid-sweep or mid-handshake, SHALL force IDLE next cycle: busy=0, done=0, dut_run=0, res_valid=0, period_out=0, res_* = 0, counters and trackers cleared.
REQ-021 rst SHALL take priority over start on the same edge.

Verification
REQ-022 NUM_CH=2, start=2, step=5, stop=12, settle=4, measure=8, res_ready=1 -> points 2,7,12; 6 results; done pulses once; dut_run low exactly 100 cycles before each point.
REQ-023 ch0 driven -3,5,-7,2 valid each MEASURE cycle, ch1 ch_valid=0 -> ch0 min=-7 max=5 res_empty=0; ch1 res_empty=1, min=0x7FFF, max=0x8000.
REQ-024 res_ready low 10 cycles during REPORT -> res_valid held high, res_channel/res_min/res_max unchanged, no result lost or duplicated.
REQ-025 step=0 or start=20, stop=10 -> exactly one point measured, NUM_CH results, done.
REQ-026 PERIOD_WIDTH=8, start=250, step=10, stop=255 -> one point (carry/overflow ends sweep), no wrap to 4.
REQ-027 rst asserted in MEASURE and again with res_valid high -> next cycle IDLE, all outputs at reset values; subsequent start runs a clean sweep.

Source files
------------

// File: rtl/sweep_response_analyzer.sv
// Purpose: steps a sine generator period across a sweep and reports per-channel min/max of the filter outputs at each point.
// Latency: tracker update 1 cycle after a valid sample; first result presented the cycle after MEASURE ends.
// Backpressure: REPORT holds res_* stable while res_ready is low; one result transfers per valid&ready cycle.
module sweep_response_analyzer #(
    parameter int WORD_WIDTH   = 16,
    parameter int NUM_CH       = 13,
    parameter int PERIOD_WIDTH = 32,
    parameter int CNT_WIDTH    = 32,
    parameter int FLUSH_CYCLES = 100
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [PERIOD_WIDTH-1:0]        period_start,
    input  logic [PERIOD_WIDTH-1:0]        period_step,
    input  logic [PERIOD_WIDTH-1:0]        period_stop,
    input  logic [CNT_WIDTH-1:0]           settle_cycles,
    input  logic [CNT_WIDTH-1:0]           measure_cycles,
    input  logic [NUM_CH*WORD_WIDTH-1:0]   ch_data,
    input  logic [NUM_CH-1:0]              ch_valid,
    output logic [PERIOD_WIDTH-1:0]        period_out,
    output logic                           dut_run,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [PERIOD_WIDTH-1:0]        res_period,
    output logic [7:0]                     res_channel,
    output logic [WORD_WIDTH-1:0]          res_min,
    output logic [WORD_WIDTH-1:0]          res_max,
    output logic                           res_empty,
    output logic                           busy,
    output logic                           done
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [WORD_WIDTH-1:0] MOST_POS   = {1'b0, {(WORD_WIDTH-1){1'b1}}};
    localparam logic [WORD_WIDTH-1:0] MOST_NEG   = {1'b1, {(WORD_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  FLUSH_LAST = CNT_WIDTH'(FLUSH_CYCLES - 1);
    localparam logic [IDX_W-1:0]      LAST_CH    = IDX_W'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, FLUSH, SETTLE, MEASURE, REPORT, NEXT} state_t;

    typedef struct packed {
        logic signed [WORD_WIDTH-1:0] mn;
        logic signed [WORD_WIDTH-1:0] mx;
        logic                         seen;
    } trk_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [PERIOD_WIDTH-1:0] step_q;
    logic [PERIOD_WIDTH-1:0] stop_q;
    logic [CNT_WIDTH-1:0]    settle_q;
    logic [CNT_WIDTH-1:0]    meas_q;
    logic [IDX_W-1:0]        ch_idx;
    trk_t                    trk_q [NUM_CH];

    logic [PERIOD_WIDTH:0]   next_sum;
    logic                    advance;
    logic                    xfer;

    // One extra bit so a wrapped period is seen as a carry rather than a small value.
    assign next_sum = {1'b0, period_out} + {1'b0, step_q};
    assign advance  = (step_q != '0) && !next_sum[PERIOD_WIDTH]
                      && (next_sum[PERIOD_WIDTH-1:0] <= stop_q);
    assign xfer     = res_valid && res_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FLUSH;
            FLUSH:   if (cnt == FLUSH_LAST)
                         state_nxt = (settle_q == '0) ? MEASURE : SETTLE;
            SETTLE:  if (cnt == settle_q - CNT_WIDTH'(1)) state_nxt = MEASURE;
            MEASURE: if (meas_q == '0 || cnt == meas_q - CNT_WIDTH'(1)) state_nxt = REPORT;
            REPORT:  if (xfer && ch_idx == LAST_CH) state_nxt = NEXT;
            NEXT:    state_nxt = advance ? FLUSH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            step_q     <= '0;
            stop_q     <= '0;
            settle_q   <= '0;
            meas_q     <= '0;
            ch_idx     <= '0;
            period_out <= '0;
            dut_run    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            res_valid  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                trk_q[k] <= '0;
            end
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            dut_run   <= (state_nxt == SETTLE) || (state_nxt == MEASURE);
            res_valid <= (state_nxt == REPORT);
            done      <= (state == NEXT) && (state_nxt == IDLE);

            if (state_nxt != state || state_nxt == IDLE || state_nxt == REPORT) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end

            if (state == IDLE && start) begin
                period_out <= period_start;
                step_q     <= period_step;
                stop_q     <= period_stop;
                settle_q   <= settle_cycles;
                meas_q     <= measure_cycles;
            end else if (state == NEXT && advance) begin
                period_out <= next_sum[PERIOD_WIDTH-1:0];
            end

            if (state != REPORT || (xfer && ch_idx == LAST_CH)) begin
                ch_idx <= '0;
            end else if (xfer) begin
                ch_idx <= ch_idx + IDX_W'(1);
            end

            // Trackers start at the opposite extremes so an empty channel reports max<min.
            for (int k = 0; k < NUM_CH; k++) begin
                if (state_nxt == MEASURE && state != MEASURE) begin
                    trk_q[k] <= '{mn: MOST_POS, mx: MOST_NEG, seen: 1'b0};
                end else if (state == MEASURE && ch_valid[k]) begin
                    if ($signed(ch_data[k*WORD_WIDTH +: WORD_WIDTH]) < $signed(trk_q[k].mn))
                        trk_q[k].mn <= ch_data[k*WORD_WIDTH +: WORD_WIDTH];
                    if ($signed(ch_data[k*WORD_WIDTH +: WORD_WIDTH]) > $signed(trk_q[k].mx))
                        trk_q[k].mx <= ch_data[k*WORD_WIDTH +: WORD_WIDTH];
                    trk_q[k].seen <= 1'b1;
                end
            end
        end
    end

    // Result word is a mux of stable registers, so it cannot move while stalled.
    assign res_period  = res_valid ? period_out : '0;
    assign res_channel = res_valid ? 8'(ch_idx) : '0;
    assign res_min     = res_valid ? trk_q[ch_idx].mn : '0;
    assign res_max     = res_valid ? trk_q[ch_idx].mx : '0;
    assign res_empty   = res_valid & ~trk_q[ch_idx].seen;

endmodule

// File: tb/tb_sweep_response_analyzer.sv
// Scoreboard bench: expected results queued per planned sweep point and compared on each handshake.
module tb_sweep_response_analyzer;

    localparam int W   = 16;
    localparam int NCH = 2;
    localparam int PW  = 8;
    localparam int CW  = 16;
    localparam int FL  = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [PW-1:0]     period_start, period_step, period_stop;
    logic [CW-1:0]     settle_cycles, measure_cycles;
    logic [NCH*W-1:0]  ch_data;
    logic [NCH-1:0]    ch_valid;
    logic [PW-1:0]     period_out;
    logic              dut_run;
    logic              res_valid;
    logic              res_ready;
    logic [PW-1:0]     res_period;
    logic [7:0]        res_channel;
    logic [W-1:0]      res_min, res_max;
    logic              res_empty;
    logic              busy;
    logic              done;

    sweep_response_analyzer #(
        .WORD_WIDTH(W), .NUM_CH(NCH), .PERIOD_WIDTH(PW), .CNT_WIDTH(CW), .FLUSH_CYCLES(FL)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .period_start(period_start), .period_step(period_step), .period_stop(period_stop),
        .settle_cycles(settle_cycles), .measure_cycles(measure_cycles),
        .ch_data(ch_data), .ch_valid(ch_valid),
        .period_out(period_out), .dut_run(dut_run),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_period(res_period), .res_channel(res_channel),
        .res_min(res_min), .res_max(res_max), .res_empty(res_empty),
        .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] period;
        logic [7:0]    ch;
        logic [W-1:0]  mn;
        logic [W-1:0]  mx;
        logic          empty;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   ch1_mode = 0;
    bit   run_chk = 1'b1;
    int   exp_hi = 0;
    int   done_cnt = 0;
    int   lo_cnt = 0;
    int   hi_cnt = 0;
    logic prev_run = 1'b0;
    int   pat_i = 0;
    logic [W-1:0] pat [4] = '{16'hFFFD, 16'h0005, 16'hFFF9, 16'h0002};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_dut_run"},   dut_run, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_period"},    period_out, 0);
        check({tag, "_res_per"},   res_period, 0);
        check({tag, "_res_ch"},    res_channel, 0);
        check({tag, "_res_min"},   res_min, 0);
        check({tag, "_res_max"},   res_max, 0);
        check({tag, "_res_empty"}, res_empty, 0);
    endtask

    // ch0 cycles through -3,5,-7,2 every cycle; ch1 is either invalid noise or a valid constant.
    initial begin
        ch_data  = '0;
        ch_valid = '0;
        forever begin
            @(posedge clk);
            #1;
            pat_i = (pat_i + 1) % 4;
            ch_data[W-1:0] = pat[pat_i];
            ch_valid[0] = 1'b1;
            if (ch1_mode == 1) begin
                ch_data[2*W-1:W] = 16'd1234;
                ch_valid[1] = 1'b1;
            end else begin
                ch_data[2*W-1:W] = 16'h7000;
                ch_valid[1] = 1'b0;
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            lo_cnt = 0;
            hi_cnt = 0;
            prev_run = 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                check("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("res_period", res_period, e.period);
                    check("res_channel", res_channel, e.ch);
                    check("res_min", res_min, e.mn);
                    check("res_max", res_max, e.mx);
                    check("res_empty", res_empty, e.empty);
                end
            end
            if (done) done_cnt++;
            if (busy && !dut_run && !res_valid && sb.size() > 0 && period_out == sb[0].period)
                lo_cnt++;
            if (dut_run) hi_cnt++;
            if (dut_run && !prev_run) begin
                if (run_chk) check("flush_len", lo_cnt, FL);
                lo_cnt = 0;
            end
            if (!dut_run && prev_run) begin
                if (run_chk) check("run_len", hi_cnt, exp_hi);
                hi_cnt = 0;
            end
            prev_run = dut_run;
        end
    end

    task automatic push_point(input logic [PW-1:0] p);
        sb.push_back('{period: p, ch: 8'd0, mn: 16'hFFF9, mx: 16'h0005, empty: 1'b0});
        if (ch1_mode == 1)
            sb.push_back('{period: p, ch: 8'd1, mn: 16'd1234, mx: 16'd1234, empty: 1'b0});
        else
            sb.push_back('{period: p, ch: 8'd1, mn: 16'h7FFF, mx: 16'h8000, empty: 1'b1});
    endtask

    task automatic plan(input logic [PW-1:0] ps, input logic [PW-1:0] st,
                        input logic [PW-1:0] sp, output logic [PW-1:0] last);
        logic [PW-1:0] p;
        logic [PW:0]   s;
        p = ps;
        last = ps;
        for (int n = 0; n < 64; n++) begin
            push_point(p);
            last = p;
            s = {1'b0, p} + {1'b0, st};
            if (st == 0 || s[PW] || s[PW-1:0] > sp) break;
            p = s[PW-1:0];
        end
    endtask

    task automatic run_sweep(input logic [PW-1:0] ps, input logic [PW-1:0] st,
                             input logic [PW-1:0] sp, input logic [CW-1:0] se,
                             input logic [CW-1:0] me, input int m1,
                             input bit stall, input bit restart);
        logic [PW-1:0] last;
        int waited;
        ch1_mode = m1;
        exp_hi   = int'(se) + ((me == 0) ? 1 : int'(me));
        done_cnt = 0;
        plan(ps, st, sp, last);
        period_start = ps; period_step = st; period_stop = sp;
        settle_cycles = se; measure_cycles = me;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        // Scramble the config after acceptance; the sweep must use the latched copy.
        period_start = 8'd77; period_step = 8'd1; period_stop = 8'd255;
        settle_cycles = 16'd7; measure_cycles = 16'd3;
        if (restart) begin
            repeat (20) @(posedge clk);
            #1 start = 1'b1; period_start = 8'd99;
            @(posedge clk); #1 start = 1'b0;
        end
        if (stall) begin
            for (waited = 0; waited < 2000; waited++) begin
                @(negedge clk);
                if (res_valid) break;
            end
            check("stall_reach", res_valid, 1);
            @(posedge clk); #1 res_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("stall_valid", res_valid, 1);
                if (sb.size() > 0) begin
                    check("stall_ch", res_channel, sb[0].ch);
                    check("stall_min", res_min, sb[0].mn);
                    check("stall_max", res_max, sb[0].mx);
                end
            end
            @(posedge clk); #1 res_ready = 1'b1;
        end
        for (waited = 0; waited < 20000; waited++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_seen", done, 1);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt, 1);
        check("sb_drained", sb.size(), 0);
        check("idle_busy", busy, 0);
        check("period_hold", period_out, last);
        sb.delete();
    endtask

    initial begin
        int waited;
        rst = 1'b1; start = 1'b0; res_ready = 1'b1;
        period_start = '0; period_step = '0; period_stop = '0;
        settle_cycles = '0; measure_cycles = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("por");
        @(posedge clk); #1 rst = 1'b0;

        // Points 2,7,12 with a spurious start mid-sweep.
        run_sweep(8'd2, 8'd5, 8'd12, 16'd4, 16'd8, 0, 1'b0, 1'b1);
        // step=0, no settle, consumer stalls during REPORT.
        run_sweep(8'd3, 8'd0, 8'd50, 16'd0, 16'd8, 1, 1'b1, 1'b0);
        // start beyond stop still measures start.
        run_sweep(8'd20, 8'd3, 8'd10, 16'd4, 16'd8, 1, 1'b0, 1'b0);
        // 250+10 carries out of 8 bits: single point.
        run_sweep(8'd250, 8'd10, 8'd255, 16'd2, 16'd5, 0, 1'b0, 1'b0);

        // Reset in MEASURE.
        run_chk = 1'b0;
        ch1_mode = 0;
        period_start = 8'd40; period_step = 8'd0; period_stop = 8'd40;
        settle_cycles = 16'd4; measure_cycles = 16'd8;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (waited = 0; waited < 500; waited++) begin
            @(negedge clk);
            if (dut_run) break;
        end
        check("rst_reach_run", dut_run, 1);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_checks("rst_meas");
        @(posedge clk); #1 rst = 1'b0;

        // Reset while a result is held, with start on the same edge.
        res_ready = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (waited = 0; waited < 500; waited++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        check("rst_reach_report", res_valid, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        reset_checks("rst_hs");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_no_start", busy, 0);
        res_ready = 1'b1;
        run_chk = 1'b1;

        // Clean sweep after the aborted ones.
        run_sweep(8'd5, 8'd1, 8'd6, 16'd2, 16'd6, 1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
